ram_mfc_responder: RTL and testbench
====================================

// Module: ram_mfc_responder
// PURPOSE
//  Byte-addressed data/instruction RAM acting as responder on the control unit's MOV/MFC memory handshake.
//  The control unit raises mov with rw/size/addr/din; this block inserts WAIT_CYCLES wait states, performs
//  the access (big-endian), then raises mfc until mov drops (4-phase). Sits between datapath MAR/MDR and CU.
// PARAMETERS
//  MEM_BYTES   512  storage depth in bytes (power of 2); addr taken modulo MEM_BYTES
//  WAIT_CYCLES 2    wait states between request capture and access (0..15)
// PORTS
//  clk       in   1   single clock, all state changes on posedge
//  rst       in   1   asynchronous, active-high reset
//  mov       in   1   memory operation valid (request), held high until mfc seen
//  rw        in   1   1 = read, 0 = write
//  size      in   2   00 byte, 01 halfword, 10 word, 11 reserved
//  addr      in   32  byte address
//  din       in   32  write data, right-justified (byte in [7:0], half in [15:0])
//  dout      out  32  read data, right-justified, zero-extended
//  mfc       out  1   memory function complete
//  busy      out  1   high in ACCESS and COMPLETE states
//  align_err out  1   only with MEM_ALIGN_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, mfc=0, busy=0, dout=0, align_err=0, wait counter=0. RAM contents not cleared.
//  FSM: IDLE -> ACCESS -> COMPLETE -> IDLE.
//   IDLE: on posedge with mov=1 latch rw,size,addr,din; cnt<=WAIT_CYCLES; go ACCESS.
//   ACCESS: if mov=0 -> abort to IDLE, no write, dout unchanged. Else if cnt!=0 cnt<=cnt-1;
//     if cnt==0 perform access on latched request, mfc<=1, go COMPLETE.
//   COMPLETE: mfc=1, dout stable; when mov=0 on posedge -> mfc<=0, go IDLE.
//     New request needs mov low for >=1 sampled edge (no back-to-back without drop).
//  Latency: mov sampled at edge N -> mfc high after edge N+1+WAIT_CYCLES (WAIT_CYCLES=0: after N+1).
//  Requests changed while busy are ignored; only the latched copy is used.
//  Addressing: a = addr mod MEM_BYTES; halfword uses a with bit0 cleared, word uses bits[1:0] cleared.
//  Big-endian: word at a: mem[a]=d[31:24], mem[a+1]=d[23:16], mem[a+2]=d[15:8], mem[a+3]=d[7:0].
//   Halfword: mem[a]=d[15:8], mem[a+1]=d[7:0]. Byte: mem[a]=d[7:0].
//  Read: dout <= zero-extended value; loaded on the same edge mfc rises.
//  Write: bytes updated on the edge mfc rises; dout unchanged on write.
//  size=11: no RAM change, dout<=0, handshake still completes normally.
//  Top address (a=MEM_BYTES-4 word) is last legal word; no wrap inside an access due to alignment.
//  Reset asserted mid-operation: immediate return to IDLE, pending write discarded, mfc=0.
//  Read and write of same address are ordered by handshake; no read-during-write case exists.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: align_err port exists; misaligned request (half with addr[0]=1, word with
//   addr[1:0]!=0) or size=11 completes with mfc=1 and align_err=1 for the COMPLETE state; writes suppressed,
//   dout<=0. align_err clears with mfc.
//  MEM_ALIGN_CHECK_EN undefined: no align_err port; misaligned addresses silently aligned down as above.
// TESTING
//  1 Reset: rst=1 mid-ACCESS of write 0xDEADBEEF @0x10 -> mfc=0, later read @0x10 returns prior value.
//  2 Word write 0x11223344 @0x20 then byte reads @0x20..0x23 -> dout 0x11,0x22,0x33,0x44.
//  3 Latency: WAIT_CYCLES=2, mov high at edge 0 -> mfc first high after edge 3; WAIT_CYCLES=0 -> edge 1.
//  4 Halfword write 0xABCD @0x31 (no check) -> mem[0x30]=0xAB, mem[0x31]=0xCD; read half @0x30 = 0x0000ABCD.
//  5 mov dropped during ACCESS of write 0xFF @0x40 -> mfc never rises, mem[0x40] unchanged, busy=0 next edge.
//  6 MEM_ALIGN_CHECK_EN: word write @0x42 -> mfc=1, align_err=1, memory unchanged; size=11 read -> dout=0, align_err=1.

Source files
------------

// File: rtl/ram_mfc_if.sv
// ram_mfc_if: MOV/MFC memory handshake between the control unit (master)
// and the RAM responder (slave).
// Optional build macro MEM_ALIGN_CHECK_EN adds the align_err signal.
interface ram_mfc_if;
    logic        mov;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mfc;
    logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;

    modport master (output mov, rw, size, addr, din, input dout, mfc, busy, align_err);
    modport slave  (input mov, rw, size, addr, din, output dout, mfc, busy, align_err);
`else
    modport master (output mov, rw, size, addr, din, input dout, mfc, busy);
    modport slave  (input mov, rw, size, addr, din, output dout, mfc, busy);
`endif
endinterface

// File: rtl/ram_mfc_responder.sv
// ram_mfc_responder: byte-addressed big-endian RAM answering the control
// unit's 4-phase MOV/MFC handshake after WAIT_CYCLES wait states.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned or reserved-size
// requests complete with align_err=1, no write and dout=0. Without it,
// addresses are silently aligned down and only size=11 is suppressed.
module ram_mfc_responder #(
    parameter int MEM_BYTES   = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    ram_mfc_if.slave  bus
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           rw_q, rw_d;
    logic [1:0]     size_q, size_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    din_q, din_d;
    logic [31:0]    dout_q, dout_d;
    logic           mfc_q, mfc_d;
    logic           busy_q, busy_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic           err_q, err_d;
`endif

    logic [7:0]     mem [MEM_BYTES];
    logic [AW-1:0]  base_s;
    logic [31:0]    rd_data_s;
    logic           bad_s;
    logic           we_s;

    // Base byte index: halfwords and words are aligned down so an access never wraps.
    always_comb begin
        case (size_q)
            2'b00:   base_s = addr_q;
            2'b01:   base_s = {addr_q[AW-1:1], 1'b0};
            default: base_s = {addr_q[AW-1:2], 2'b00};
        endcase
    end

    // Big-endian read assembly, right-justified and zero-extended.
    always_comb begin
        case (size_q)
            2'b00:   rd_data_s = {24'h000000, mem[base_s]};
            2'b01:   rd_data_s = {16'h0000, mem[base_s], mem[base_s + AW'(1)]};
            2'b10:   rd_data_s = {mem[base_s], mem[base_s + AW'(1)],
                                  mem[base_s + AW'(2)], mem[base_s + AW'(3)]};
            default: rd_data_s = 32'h00000000;
        endcase
    end

    // Requests that must complete without touching the RAM.
    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        bad_s = (size_q == 2'b11) ||
                ((size_q == 2'b01) && addr_q[0]) ||
                ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        bad_s = (size_q == 2'b11);
`endif
    end

    // Handshake FSM: capture, count wait states, access, hold mfc until mov drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        we_s    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.mov) begin
                    rw_d    = bus.rw;
                    size_d  = bus.size;
                    addr_d  = bus.addr[AW-1:0];
                    din_d   = bus.din;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (!bus.mov) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mfc_d   = 1'b1;
                    state_d = S_COMPLETE;
                    if (bad_s) begin
                        dout_d = 32'h00000000;
`ifdef MEM_ALIGN_CHECK_EN
                        err_d  = 1'b1;
`endif
                    end else if (rw_q) begin
                        dout_d = rd_data_s;
                    end else begin
                        we_s = 1'b1;
                    end
                end
            end
            S_COMPLETE: begin
                if (!bus.mov) begin
                    mfc_d   = 1'b0;
                    state_d = S_IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_COMPLETE;
                end
            end
            default: begin
                state_d = S_IDLE;
                mfc_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset returns to IDLE and drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            din_q   <= 32'h00000000;
            dout_q  <= 32'h00000000;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            busy_q  <= busy_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Big-endian byte-lane writes on the edge mfc rises; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            case (size_q)
                2'b00: mem[base_s] <= din_q[7:0];
                2'b01: begin
                    mem[base_s]         <= din_q[15:8];
                    mem[base_s + AW'(1)] <= din_q[7:0];
                end
                2'b10: begin
                    mem[base_s]         <= din_q[31:24];
                    mem[base_s + AW'(1)] <= din_q[23:16];
                    mem[base_s + AW'(2)] <= din_q[15:8];
                    mem[base_s + AW'(3)] <= din_q[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.mfc  = mfc_q;
    assign bus.busy = busy_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.align_err = err_q;
`endif
endmodule

// File: tb/tb_ram_mfc_responder.sv
// Directed, table-driven bench for ram_mfc_responder (WAIT_CYCLES=2 main
// instance, WAIT_CYCLES=0 instance for latency). Honours MEM_ALIGN_CHECK_EN.
module tb_ram_mfc_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_mfc_if bus ();
    ram_mfc_if bus0 ();

    ram_mfc_responder #(.MEM_BYTES(512), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    ram_mfc_responder #(.MEM_BYTES(512), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
        logic        illegal;
    } vec_t;

    vec_t tbl [18];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Full 4-phase transaction on the main instance; returns dout, align flag, latency.
    task automatic do_op(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] din, output logic [31:0] d, output logic err,
                         output int cyc);
        @(negedge clk);
        bus.mov = 1'b1; bus.rw = rw; bus.size = size; bus.addr = addr; bus.din = din;
        cyc = 0;
        while (bus.mfc !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("handshake_timeout", {31'd0, bus.mfc}, 32'd1);
        d = bus.dout;
`ifdef MEM_ALIGN_CHECK_EN
        err = bus.align_err;
`else
        err = 1'b0;
`endif
        bus.mov = 1'b0; bus.rw = ~rw; bus.addr = 32'hFFFF_FFFF; bus.din = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("mfc_drop", {31'd0, bus.mfc}, 32'd0);
        chk("busy_drop", {31'd0, bus.busy}, 32'd0);
    endtask

    logic [31:0] d;
    logic        e;
    int          cyc;

    initial begin
        bus.mov = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.addr = 32'd0; bus.din = 32'd0;
        bus0.mov = 1'b0; bus0.rw = 1'b0; bus0.size = 2'b00; bus0.addr = 32'd0; bus0.din = 32'd0;

        //           rw    size   addr         din           exp dout     illegal
        tbl[0]  = '{1'b0, 2'b10, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 32'h0000_0020, 32'h0,         32'h0000_0011, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 32'h0000_0021, 32'h0,         32'h0000_0022, 1'b0};
        tbl[3]  = '{1'b1, 2'b00, 32'h0000_0022, 32'h0,         32'h0000_0033, 1'b0};
        tbl[4]  = '{1'b1, 2'b00, 32'h0000_0023, 32'h0,         32'h0000_0044, 1'b0};
        tbl[5]  = '{1'b1, 2'b01, 32'h0000_0022, 32'h0,         32'h0000_3344, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, 32'h0000_0030, 32'hFFFF_ABCD, 32'h0000_3344, 1'b0};
        tbl[7]  = '{1'b1, 2'b01, 32'h0000_0030, 32'h0,         32'h0000_ABCD, 1'b0};
        tbl[8]  = '{1'b1, 2'b00, 32'h0000_0031, 32'h0,         32'h0000_00CD, 1'b0};
        tbl[9]  = '{1'b0, 2'b10, 32'h0000_01FC, 32'h5566_7788, 32'h0000_00CD, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 32'h0000_01FC, 32'h0,         32'h5566_7788, 1'b0};
        tbl[11] = '{1'b1, 2'b10, 32'h0000_21FC, 32'h0,         32'h5566_7788, 1'b0};
        tbl[12] = '{1'b1, 2'b00, 32'h0000_01FF, 32'h0,         32'h0000_0088, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 32'h0000_01FE, 32'hFFFF_FF99, 32'h0000_0088, 1'b0};
        tbl[14] = '{1'b1, 2'b10, 32'h0000_01FC, 32'h0,         32'h5566_9988, 1'b0};
        tbl[15] = '{1'b1, 2'b11, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b1};
        tbl[16] = '{1'b0, 2'b11, 32'h0000_0020, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1};
        tbl[17] = '{1'b1, 2'b10, 32'h0000_0020, 32'h0,         32'h1122_3344, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mfc", {31'd0, bus.mfc}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_align_err", {31'd0, bus.align_err}, 32'd0);
`endif
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            do_op(tbl[i].rw, tbl[i].size, tbl[i].addr, tbl[i].din, d, e, cyc);
            chk($sformatf("vec%0d_dout", i), d, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), cyc, 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
            chk($sformatf("vec%0d_align_err", i), {31'd0, e}, {31'd0, tbl[i].illegal});
`endif
        end

        // Latency on the zero-wait instance: mfc first seen after edge 1
        @(negedge clk);
        bus0.mov = 1'b1; bus0.rw = 1'b0; bus0.size = 2'b00; bus0.addr = 32'h4; bus0.din = 32'h5;
        cyc = 0;
        while (bus0.mfc !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("w0_latency", cyc, 32'd2);
        bus0.mov = 1'b0;
        @(negedge clk);
        chk("w0_mfc_drop", {31'd0, bus0.mfc}, 32'd0);

        // Reset in the middle of a write access
        do_op(1'b0, 2'b10, 32'h10, 32'hCAFE_F00D, d, e, cyc);
        @(negedge clk);
        bus.mov = 1'b1; bus.rw = 1'b0; bus.size = 2'b10; bus.addr = 32'h10; bus.din = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("midop_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mfc", {31'd0, bus.mfc}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        bus.mov = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst_mfc", {31'd0, bus.mfc}, 32'd0);
        do_op(1'b1, 2'b10, 32'h10, 32'h0, d, e, cyc);
        chk("postrst_read", d, 32'hCAFE_F00D);

        // mov dropped during ACCESS aborts the write
        do_op(1'b0, 2'b00, 32'h40, 32'h77, d, e, cyc);
        @(negedge clk);
        bus.mov = 1'b1; bus.rw = 1'b0; bus.size = 2'b00; bus.addr = 32'h40; bus.din = 32'hFF;
        @(negedge clk);
        chk("abort_busy_hi", {31'd0, bus.busy}, 32'd1);
        bus.mov = 1'b0;
        @(negedge clk);
        chk("abort_busy_lo", {31'd0, bus.busy}, 32'd0);
        chk("abort_mfc", {31'd0, bus.mfc}, 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_mfc_late", {31'd0, bus.mfc}, 32'd0);
        do_op(1'b1, 2'b00, 32'h40, 32'h0, d, e, cyc);
        chk("abort_mem", d, 32'h77);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word write completes with align_err and leaves memory alone
        do_op(1'b0, 2'b10, 32'h40, 32'h0102_0304, d, e, cyc);
        do_op(1'b0, 2'b10, 32'h42, 32'hDEAD_BEEF, d, e, cyc);
        chk("mis_word_err", {31'd0, e}, 32'd1);
        chk("mis_word_err_clr", {31'd0, bus.align_err}, 32'd0);
        do_op(1'b1, 2'b01, 32'h31, 32'h0, d, e, cyc);
        chk("mis_half_err", {31'd0, e}, 32'd1);
        chk("mis_half_dout", d, 32'h0);
        do_op(1'b1, 2'b10, 32'h40, 32'h0, d, e, cyc);
        chk("mis_mem", d, 32'h0102_0304);
        chk("mis_ok_err", {31'd0, e}, 32'd0);
`else
        // Misaligned halfword write is aligned down silently
        do_op(1'b0, 2'b01, 32'h31, 32'h0000_1234, d, e, cyc);
        do_op(1'b1, 2'b01, 32'h30, 32'h0, d, e, cyc);
        chk("mis_half_read", d, 32'h0000_1234);
        do_op(1'b1, 2'b00, 32'h31, 32'h0, d, e, cyc);
        chk("mis_half_byte1", d, 32'h0000_0034);
        do_op(1'b1, 2'b10, 32'h23, 32'h0, d, e, cyc);
        chk("mis_word_read", d, 32'h1122_3344);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
